// File: rtl/dsi_ppi_lane_ctrl_if.sv
// Beat stream from the DSI packet builder into the PPI lane controller.
// The master side is the packet builder and the slave side is the lane controller.
interface dsi_ppi_lane_ctrl_if;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic [1:0]  s_nbytes;
  logic        s_ready;

  modport master (output s_valid, output s_data, output s_last, output s_nbytes, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, input s_nbytes, output s_ready);
endinterface

// File: rtl/dsi_ppi_lane_ctrl.sv
// HS burst controller for the DSI PPI transmit path: PREP, SYNC, payload and TRAIL on 1-4 lanes.
// Optional DSI_LANE_STATS_EN adds a saturating burst_cnt output.
module dsi_ppi_lane_ctrl #(
  parameter int unsigned HS_PREP_CYCLES = 2,
  parameter int unsigned TRAIL_CYCLES   = 4,
  parameter logic [7:0]  SYNC_BYTE      = 8'hB8
) (
  input  logic               ppi_clk,
  input  logic               ppi_rst_n,
  input  logic [1:0]         cfg_lane_cnt,
  dsi_ppi_lane_ctrl_if.slave s_bus,
  input  logic               err_clr,
  output logic [7:0]         PPI_DATA_LANE0,
  output logic [7:0]         PPI_DATA_LANE1,
  output logic [7:0]         PPI_DATA_LANE2,
  output logic [7:0]         PPI_DATA_LANE3,
  output logic               PPI_LANE0_EN,
  output logic               PPI_LANE1_EN,
  output logic               PPI_LANE2_EN,
  output logic               PPI_LANE3_EN,
  output logic               busy,
  output logic               underrun_err
`ifdef DSI_LANE_STATS_EN
  , output logic [15:0]      burst_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, PREP, SYNC, SEND, TRAIL} state_t;

  localparam logic [3:0] PREP_LOAD   = 4'(HS_PREP_CYCLES - 1);
  localparam logic [3:0] TRAIL_LOAD  = 4'(TRAIL_CYCLES);
  localparam logic [3:0] TRAIL_ABORT = 4'(TRAIL_CYCLES - 1);

  state_t          state, state_nx;
  logic [3:0]      cnt, cnt_nx;
  logic [1:0]      lanes_q, lanes_nx;
  logic [3:0]      en_q, en_nx;
  logic [3:0][7:0] data_q, data_nx;
  logic [3:0][7:0] last_q, last_nx;
  logic            err_q, err_nx;
  logic            ready;
  logic            underrun;
  logic [1:0]      nb_clamp;

  function automatic logic [7:0] trail_of(input logic [7:0] b);
    trail_of = {8{~b[7]}};
  endfunction

  assign ready          = (state == SYNC) || (state == SEND);
  assign s_bus.s_ready  = ready;
  assign underrun       = ready && !s_bus.s_valid;
  assign nb_clamp       = (s_bus.s_nbytes > lanes_q) ? lanes_q : s_bus.s_nbytes;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lanes_nx = lanes_q;
    en_nx    = en_q;
    data_nx  = data_q;
    last_nx  = last_q;
    err_nx   = err_q;
    if (underrun)     err_nx = 1'b1;
    else if (err_clr) err_nx = 1'b0;

    case (state)
      IDLE: if (s_bus.s_valid) begin
        lanes_nx = cfg_lane_cnt;
        en_nx    = 4'b1111 >> (2'd3 - cfg_lane_cnt);
        data_nx  = '0;
        cnt_nx   = PREP_LOAD;
        state_nx = PREP;
      end
      PREP: begin
        if (cnt == '0) begin
          state_nx = SYNC;
          for (int unsigned i = 0; i < 4; i++)
            if (en_q[i]) begin
              data_nx[i] = SYNC_BYTE;
              last_nx[i] = SYNC_BYTE;
            end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      SYNC, SEND: begin
        if (s_bus.s_valid) begin
          // Lanes beyond the final byte count begin trailing alongside the last payload.
          for (int unsigned i = 0; i < 4; i++)
            if (en_q[i]) begin
              if (!s_bus.s_last || i <= 32'(nb_clamp)) begin
                data_nx[i] = s_bus.s_data[8*i +: 8];
                last_nx[i] = s_bus.s_data[8*i +: 8];
              end else begin
                data_nx[i] = trail_of(last_q[i]);
              end
            end
          if (s_bus.s_last) begin
            state_nx = TRAIL;
            cnt_nx   = TRAIL_LOAD;
          end else begin
            state_nx = SEND;
          end
        end else begin
          for (int unsigned i = 0; i < 4; i++)
            if (en_q[i]) data_nx[i] = trail_of(last_q[i]);
          state_nx = TRAIL;
          cnt_nx   = TRAIL_ABORT;
        end
      end
      TRAIL: begin
        if (cnt == '0) begin
          state_nx = IDLE;
          en_nx    = '0;
          data_nx  = '0;
        end else begin
          for (int unsigned i = 0; i < 4; i++)
            if (en_q[i]) data_nx[i] = trail_of(last_q[i]);
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ppi_clk or negedge ppi_rst_n) begin
    if (!ppi_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      lanes_q <= '0;
      en_q    <= '0;
      data_q  <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      lanes_q <= lanes_nx;
      en_q    <= en_nx;
      data_q  <= data_nx;
      last_q  <= last_nx;
      err_q   <= err_nx;
    end
  end

`ifdef DSI_LANE_STATS_EN
  always_ff @(posedge ppi_clk or negedge ppi_rst_n) begin
    if (!ppi_rst_n)
      burst_cnt <= '0;
    else if (state == TRAIL && cnt == '0 && burst_cnt != '1)
      burst_cnt <= burst_cnt + 16'd1;
  end
`endif

  assign PPI_DATA_LANE0 = data_q[0];
  assign PPI_DATA_LANE1 = data_q[1];
  assign PPI_DATA_LANE2 = data_q[2];
  assign PPI_DATA_LANE3 = data_q[3];
  assign PPI_LANE0_EN   = en_q[0];
  assign PPI_LANE1_EN   = en_q[1];
  assign PPI_LANE2_EN   = en_q[2];
  assign PPI_LANE3_EN   = en_q[3];
  assign busy           = (state != IDLE);
  assign underrun_err   = err_q;

endmodule
